// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and helpers for the memory port scheduler: FSM state encoding
// plus one-hot <-> index conversion used when registering the owner.
package mem_port_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Widest requester vector the helpers accept.
  localparam int MaxReq     = 32;
  localparam int MaxReqBits = 5;

  function automatic logic [MaxReq-1:0] idx_to_onehot(input int unsigned idx);
    logic [MaxReq-1:0] v;
    v = {{(MaxReq-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int k = 0; k < MaxReq; k++) begin
      if (v[k[MaxReqBits-1:0]]) begin
        idx = int'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Client-side request bus plus memory-side bus of the scheduler. The slave
// modport is the scheduler's view; master is the clients/memory view.
interface mem_port_scheduler_if #(
  parameter int Count     = 3,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32
);

  logic [Count-1:0]           req_i;
  logic [Count-1:0]           we_i;
  logic [Count*AddrWidth-1:0] addr_i;
  logic [Count*DataWidth-1:0] wdata_i;
  logic [Count-1:0]           grant_o;
  logic [Count-1:0]           ack_o;
  logic [DataWidth-1:0]       rdata_o;

  logic                       mem_req_o;
  logic                       mem_we_o;
  logic [AddrWidth-1:0]       mem_addr_o;
  logic [DataWidth-1:0]       mem_wdata_o;
  logic                       mem_ack_i;
  logic [DataWidth-1:0]       mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output grant_o, ack_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  grant_o, ack_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_scheduler_rr_picker.sv
// Combinational round-robin pick: first set request at or after start_i,
// wrapping past N-1 to 0; returns one-hot, zero when nothing is requested.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_lsb;

  // Rotate so start_i lands on bit 0, isolate the lowest set bit, rotate back.
  assign w_rot  = (req_i >> start_i) | (req_i << (N - int'(start_i)));
  assign w_lsb  = w_rot & (-w_rot);
  assign pick_o = (w_lsb << start_i) | (w_lsb >> (N - int'(start_i)));

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one single-port memory bus between Count requesters using a sticky
// grant bounded by MaxHold, with round-robin hand-over to the next requester.
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int Count     = 3,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int MaxHold   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_port_scheduler_if.slave  bus
);

  localparam int OwnerWidth = (Count > 1) ? $clog2(Count) : 1;
  localparam int HoldWidth  = $clog2(MaxHold + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [OwnerWidth-1:0] r_last_owner;
  logic [OwnerWidth-1:0] w_owner_next;
  logic [HoldWidth-1:0]  r_hold_cnt;
  logic [HoldWidth-1:0]  w_hold_next;

  logic [OwnerWidth-1:0] w_start;
  logic [Count-1:0]      w_pick;
  logic [MaxReq-1:0]     w_pick_full;
  logic [Count-1:0]      w_last_oh;
  logic                  w_only_last;
  logic                  w_keep;

  logic [AddrWidth-1:0]  w_addr_arr  [Count];
  logic [DataWidth-1:0]  w_wdata_arr [Count];

  genvar gi;
  generate
    for (gi = 0; gi < Count; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = bus.addr_i[gi*AddrWidth +: AddrWidth];
      assign w_wdata_arr[gi] = bus.wdata_i[gi*DataWidth +: DataWidth];
    end
  endgenerate

  assign w_start   = (r_last_owner == OwnerWidth'(Count - 1)) ? '0 : r_last_owner + OwnerWidth'(1);
  assign w_last_oh = Count'(1) << r_last_owner;

  rr_picker #(
    .N  (Count),
    .IW (OwnerWidth)
  ) u_rr_picker (
    .req_i   (bus.req_i),
    .start_i (w_start),
    .pick_o  (w_pick)
  );

  always_comb begin
    w_pick_full = '0;
    w_pick_full[Count-1:0] = w_pick;
  end

  // A lone requester keeps the bus past MaxHold since nobody is waiting.
  assign w_only_last = (bus.req_i == w_last_oh);
  assign w_keep      = bus.req_i[r_last_owner] &&
                       ((r_hold_cnt < HoldWidth'(MaxHold)) || w_only_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_owner <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_owner_next;
      r_hold_cnt   <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_last_owner;
    w_hold_next  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_i != '0) begin
          w_state_next = BUSY;
          if (w_keep) begin
            if (r_hold_cnt < HoldWidth'(MaxHold)) begin
              w_hold_next = r_hold_cnt + HoldWidth'(1);
            end
          end else begin
            w_owner_next = OwnerWidth'(onehot_to_idx(w_pick_full));
            w_hold_next  = HoldWidth'(1);
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.grant_o     = '0;
    bus.ack_o       = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = w_addr_arr[r_last_owner];
    bus.mem_wdata_o = w_wdata_arr[r_last_owner];
    bus.rdata_o     = bus.mem_rdata_i;
    if (r_state == BUSY) begin
      bus.grant_o   = w_last_oh;
      bus.mem_req_o = 1'b1;
      bus.mem_we_o  = bus.we_i[r_last_owner];
      if (bus.mem_ack_i) begin
        bus.ack_o = w_last_oh;
      end
    end
  end

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.grant_o));
  a_ack_in_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    ((bus.ack_o & ~bus.grant_o) == '0));
  a_req_matches_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.mem_req_o == (bus.grant_o != '0)));
  a_owner_holds_req: assert property (@(posedge clk_i) disable iff (rst_i)
    ((r_state == BUSY) |-> bus.req_i[r_last_owner]));

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: reset, single read, contention rotation,
// lone hog, write path and reset while a transfer is outstanding.
module tb_mem_port_scheduler;

  localparam int Count     = 3;
  localparam int AddrWidth = 16;
  localparam int DataWidth = 32;
  localparam int MaxHold   = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  mem_port_scheduler_if #(
    .Count(Count), .AddrWidth(AddrWidth), .DataWidth(DataWidth)
  ) bus ();

  mem_port_scheduler #(
    .Count(Count), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MaxHold(MaxHold)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i       = '0;
    bus.we_i        = '0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  // Waits (bounded) for a grant, acks it with rd and reports what was seen.
  task automatic run_xfer(input logic [31:0] rd, output logic [2:0] g,
                          output logic [2:0] a, output logic [31:0] r, output int gap);
    gap = 0;
    while (bus.grant_o == 3'b000 && gap < 20) begin
      tick();
      gap++;
    end
    g = bus.grant_o;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = rd;
    #1;
    a = bus.ack_o;
    r = bus.rdata_o;
    $display("xfer grant=%b ack=%b rdata=%h wait=%0d", g, a, r, gap);
    tick();
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL reset_grant got=%b exp=000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.ack_o !== 3'b000) $display("FAIL reset_ack got=%b exp=000", bus.ack_o); else n_pass++;
    rst_i = 1'b0;
    tick();
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL reset_idle_grant got=%b exp=000", bus.grant_o); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_single();
    bus.req_i = 3'b010;
    bus.we_i  = 3'b000;
    bus.addr_i[1*AddrWidth +: AddrWidth] = 16'h0010;
    #1;
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL single_pre_grant got=%b exp=000", bus.grant_o); else n_pass++;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.grant_o !== 3'b010) $display("FAIL single_grant c=%0d got=%b exp=010", c, bus.grant_o); else n_pass++;
      n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL single_mem_req c=%0d got=%b exp=1", c, bus.mem_req_o); else n_pass++;
      n_checks++; if (bus.mem_addr_o !== 16'h0010) $display("FAIL single_addr c=%0d got=%h exp=0010", c, bus.mem_addr_o); else n_pass++;
      n_checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL single_we c=%0d got=%b exp=0", c, bus.mem_we_o); else n_pass++;
      if (c == 2) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0000_CAFE;
        #1;
        n_checks++; if (bus.ack_o !== 3'b010) $display("FAIL single_ack got=%b exp=010", bus.ack_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 32'h0000_CAFE) $display("FAIL single_rdata got=%h exp=0000cafe", bus.rdata_o); else n_pass++;
      end else begin
        n_checks++; if (bus.ack_o !== 3'b000) $display("FAIL single_early_ack c=%0d got=%b exp=000", c, bus.ack_o); else n_pass++;
      end
      tick();
    end
    bus.mem_ack_i = 1'b0;
    bus.req_i     = 3'b000;
    #1;
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL single_post_grant got=%b exp=000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL single_post_req got=%b exp=0", bus.mem_req_o); else n_pass++;
    $display("single read owner=1 addr=0010 rdata=0000cafe");
  endtask

  task automatic test_contention();
    logic [2:0]  exp_g [13];
    logic [2:0]  g;
    logic [2:0]  a;
    logic [31:0] r;
    int          gap;
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
              3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    idle_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.req_i = 3'b111;
    for (int i = 0; i < 13; i++) begin
      run_xfer(32'h1000 + 32'(i), g, a, r, gap);
      n_checks++; if (g !== exp_g[i]) $display("FAIL contention_grant i=%0d got=%b exp=%b", i, g, exp_g[i]); else n_pass++;
      n_checks++; if (a !== exp_g[i]) $display("FAIL contention_ack i=%0d got=%b exp=%b", i, a, exp_g[i]); else n_pass++;
      n_checks++; if (r !== 32'h1000 + 32'(i)) $display("FAIL contention_rdata i=%0d got=%h exp=%h", i, r, 32'h1000 + 32'(i)); else n_pass++;
      n_checks++; if (gap !== 1) $display("FAIL contention_gap i=%0d got=%0d exp=1", i, gap); else n_pass++;
    end
  endtask

  task automatic test_lone_hog();
    logic [2:0]  g;
    logic [2:0]  a;
    logic [31:0] r;
    int          gap;
    bus.req_i = 3'b001;
    for (int i = 0; i < 10; i++) begin
      run_xfer(32'h2000 + 32'(i), g, a, r, gap);
      n_checks++; if (g !== 3'b001) $display("FAIL hog_grant i=%0d got=%b exp=001", i, g); else n_pass++;
      n_checks++; if (gap !== 1) $display("FAIL hog_gap i=%0d got=%0d exp=1", i, gap); else n_pass++;
    end
    bus.req_i = 3'b000;
    tick();
  endtask

  task automatic test_write();
    bus.req_i = 3'b100;
    bus.we_i  = 3'b100;
    bus.addr_i[2*AddrWidth +: AddrWidth]  = 16'h0020;
    bus.wdata_i[2*DataWidth +: DataWidth] = 32'h0000_1234;
    #1;
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL write_pre_grant got=%b exp=000", bus.grant_o); else n_pass++;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.grant_o !== 3'b100) $display("FAIL write_grant c=%0d got=%b exp=100", c, bus.grant_o); else n_pass++;
      n_checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL write_we c=%0d got=%b exp=1", c, bus.mem_we_o); else n_pass++;
      n_checks++; if (bus.mem_addr_o !== 16'h0020) $display("FAIL write_addr c=%0d got=%h exp=0020", c, bus.mem_addr_o); else n_pass++;
      n_checks++; if (bus.mem_wdata_o !== 32'h0000_1234) $display("FAIL write_wdata c=%0d got=%h exp=00001234", c, bus.mem_wdata_o); else n_pass++;
      if (c < 2) tick();
    end
    bus.mem_ack_i = 1'b1;
    #1;
    n_checks++; if (bus.ack_o !== 3'b100) $display("FAIL write_ack got=%b exp=100", bus.ack_o); else n_pass++;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.req_i     = 3'b000;
    bus.we_i      = 3'b000;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL write_post_req got=%b exp=0", bus.mem_req_o); else n_pass++;
    $display("write owner=2 addr=0020 wdata=00001234");
  endtask

  task automatic test_reset_mid_busy();
    bus.req_i = 3'b010;
    bus.addr_i[1*AddrWidth +: AddrWidth] = 16'h0044;
    tick();
    n_checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL midrst_busy_req got=%b exp=1", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.grant_o !== 3'b010) $display("FAIL midrst_busy_grant got=%b exp=010", bus.grant_o); else n_pass++;
    rst_i     = 1'b1;
    bus.req_i = 3'b000;
    tick();
    rst_i = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL midrst_req got=%b exp=0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL midrst_grant got=%b exp=000", bus.grant_o); else n_pass++;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.ack_o !== 3'b000) $display("FAIL midrst_late_ack got=%b exp=000", bus.ack_o); else n_pass++;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    n_checks++; if (bus.grant_o !== 3'b000) $display("FAIL midrst_after_grant got=%b exp=000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL midrst_after_req got=%b exp=0", bus.mem_req_o); else n_pass++;
    $display("reset mid-busy owner=1 abandoned");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lone_hog();
    test_write();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
